// File: rtl/axis_sequence_checker_if.sv
// axis_sequence_checker_if: stream handshake bundle between a counter source and the checker sink.
interface axis_sequence_checker_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] idata;
  logic ivalid;
  logic iready;
  modport master (output idata, ivalid, input iready);
  modport slave (input idata, ivalid, output iready);
endinterface

// File: rtl/axis_sequence_checker.sv
// axis_sequence_checker: stream sink that applies periodic back-pressure and checks a modulo counter sequence.
module axis_sequence_checker #(
  parameter int WIDTH = 8,
  parameter int STALL_PERIOD = 0,
  parameter int ERRW = 16
) (
  input  logic clock,
  input  logic resetn,
  axis_sequence_checker_if.slave s,
  output logic [WIDTH-1:0] expected,
  output logic locked,
  output logic [ERRW-1:0] errors,
  output logic [ERRW-1:0] beats,
  output logic protocol_error
);
  localparam int PW = STALL_PERIOD > 2 ? $clog2(STALL_PERIOD) : 1;
  localparam logic [PW-1:0] LAST = PW'(STALL_PERIOD > 1 ? STALL_PERIOD - 1 : 0);
  typedef enum logic {HUNT, TRACK} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic iready_q, iready_d;
  logic [WIDTH-1:0] expected_q, expected_d, sdata_q, sdata_d;
  logic [ERRW-1:0] errors_q, errors_d, beats_q, beats_d;
  logic stalled_q, stalled_d, pe_q, pe_d, xfer;
  always_comb begin
    phase_d = (STALL_PERIOD <= 1 || phase_q == LAST) ? '0 : phase_q + 1'b1;
    iready_d = STALL_PERIOD <= 1 || phase_d != LAST;
    xfer = s.ivalid && iready_q;
    state_d = state_q;
    expected_d = expected_q;
    errors_d = errors_q;
    beats_d = beats_q;
    if (xfer) begin
      // a match and a resync both leave expected at idata+1
      state_d = TRACK;
      expected_d = s.idata + 1'b1;
      beats_d = beats_q + 1'b1;
      errors_d = (state_q == TRACK && s.idata != expected_q && errors_q != '1) ? errors_q + 1'b1 : errors_q;
    end
    stalled_d = s.ivalid && !iready_q;
    sdata_d = s.idata;
    pe_d = pe_q || (stalled_q && (!s.ivalid || s.idata != sdata_q));
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= HUNT;
      phase_q <= '0;
      iready_q <= 1'b0;
      expected_q <= '0;
      errors_q <= '0;
      beats_q <= '0;
      stalled_q <= 1'b0;
      sdata_q <= '0;
      pe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      iready_q <= iready_d;
      expected_q <= expected_d;
      errors_q <= errors_d;
      beats_q <= beats_d;
      stalled_q <= stalled_d;
      sdata_q <= sdata_d;
      pe_q <= pe_d;
    end
  end
  assign s.iready = iready_q;
  assign expected = expected_q;
  assign locked = state_q == TRACK;
  assign errors = errors_q;
  assign beats = beats_q;
  assign protocol_error = pe_q;
endmodule

// File: tb/tb_axis_sequence_checker.sv
// tb_axis_sequence_checker: directed stimulus with a transfer scoreboard for the sequence checker (STALL_PERIOD=4, ERRW=4).
module tb_axis_sequence_checker;
  typedef struct packed {
    logic [7:0] exp;
    logic [3:0] err;
    logic [3:0] bts;
    logic lck;
    logic pe;
  } exp_t;
  logic clock = 1'b0;
  logic resetn = 1'b1;
  logic [7:0] expected;
  logic locked;
  logic [3:0] errors, beats;
  logic protocol_error;
  int passed = 0;
  int total = 0;
  int cyc = 0;
  exp_t q[$];
  exp_t e_mon, a_mon;
  bit pend = 0;
  bit pat[12] = '{0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0};
  logic [7:0] vdata[6] = '{8'd254, 8'd255, 8'd0, 8'd1, 8'd7, 8'd8};
  exp_t vexp[6];
  logic [7:0] m_e, m_d;
  logic [3:0] m_err, m_b;

  axis_sequence_checker_if #(.WIDTH(8)) s ();
  axis_sequence_checker #(.WIDTH(8), .STALL_PERIOD(4), .ERRW(4)) dut (
    .clock(clock), .resetn(resetn), .s(s), .expected(expected), .locked(locked),
    .errors(errors), .beats(beats), .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  function automatic exp_t mk(input logic [7:0] x, input logic [3:0] er, input logic [3:0] b, input logic l, input logic p);
    mk = {x, er, b, l, p};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0d want %0d", nm, act, want);
  endtask

  always @(negedge clock) begin
    if (pend) begin
      total++;
      if (q.size() == 0) $display("FAIL sb_empty: transfer seen with data=%0d but no expectation queued", s.idata);
      else begin
        e_mon = q.pop_front();
        a_mon = {expected, errors, beats, locked, protocol_error};
        if (a_mon === e_mon) passed++;
        else $display("FAIL sb_beat: got exp=%0d err=%0d beats=%0d lck=%0b pe=%0b want exp=%0d err=%0d beats=%0d lck=%0b pe=%0b",
                      a_mon.exp, a_mon.err, a_mon.bts, a_mon.lck, a_mon.pe, e_mon.exp, e_mon.err, e_mon.bts, e_mon.lck, e_mon.pe);
      end
    end
    pend = resetn && s.ivalid && s.iready;
  end

  task automatic send(input logic [7:0] d, input exp_t e);
    int n = 0;
    bit acc = 0;
    s.idata = d;
    s.ivalid = 1'b1;
    while (!acc && n < 8) begin
      @(negedge clock);
      acc = s.iready;
      @(posedge clock);
      #1;
      n++;
    end
    cyc += n;
    if (acc) q.push_back(e);
    else begin
      total++;
      $display("FAIL send_timeout: beat %0d not accepted, got iready=%0b want 1", d, s.iready);
    end
  endtask

  task automatic do_reset();
    s.ivalid = 1'b0;
    s.idata = '0;
    @(negedge clock);
    #1 resetn = 1'b0;
    #1;
    chk("rst_iready", 32'(s.iready), 32'd0);
    chk("rst_expected", 32'(expected), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_errors", 32'(errors), 32'd0);
    chk("rst_beats", 32'(beats), 32'd0);
    chk("rst_perr", 32'(protocol_error), 32'd0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    s.ivalid = 1'b0;
    s.idata = '0;
    vexp = '{mk(8'd255, 4'd0, 4'd1, 1'b1, 1'b0), mk(8'd0, 4'd0, 4'd2, 1'b1, 1'b0), mk(8'd1, 4'd0, 4'd3, 1'b1, 1'b0),
             mk(8'd2, 4'd0, 4'd4, 1'b1, 1'b0), mk(8'd8, 4'd1, 4'd5, 1'b1, 1'b0), mk(8'd9, 4'd1, 4'd6, 1'b1, 1'b0)};
    do_reset();
    chk("iready_0", 32'(s.iready), 32'(pat[0]));
    for (int k = 1; k < 12; k++) begin
      @(posedge clock);
      #1 chk($sformatf("iready_%0d", k), 32'(s.iready), 32'(pat[k]));
    end
    chk("idle_beats", 32'(beats), 32'd0);
    chk("idle_locked", 32'(locked), 32'd0);
    cyc = 0;
    for (int i = 0; i < 12; i++) send(8'(i), mk(8'(i + 1), 4'd0, 4'(i + 1), 1'b1, 1'b0));
    chk("stream_cycles", 32'(cyc), 32'd16);
    s.ivalid = 1'b0;
    @(negedge clock);
    #1 chk("pre_reset_beats", 32'(beats), 32'd12);
    do_reset();
    send(8'd100, mk(8'd101, 4'd0, 4'd1, 1'b1, 1'b0));
    do_reset();
    for (int i = 0; i < 6; i++) send(vdata[i], vexp[i]);
    m_e = 8'd9;
    m_err = 4'd1;
    m_b = 4'd6;
    for (int i = 0; i < 20; i++) begin
      m_d = m_e + 8'd2;
      m_e = m_d + 8'd1;
      m_err = (m_err == 4'd15) ? 4'd15 : m_err + 4'd1;
      m_b = m_b + 4'd1;
      send(m_d, mk(m_e, m_err, m_b, 1'b1, 1'b0));
    end
    s.ivalid = 1'b0;
    @(negedge clock);
    #1;
    chk("sat_errors", 32'(errors), 32'd15);
    chk("sat_beats", 32'(beats), 32'd10);
    do_reset();
    s.ivalid = 1'b1;
    s.idata = 8'd5;
    @(posedge clock);
    #1 s.ivalid = 1'b0;
    chk("drop_pe_edge1", 32'(protocol_error), 32'd0);
    @(posedge clock);
    #1 chk("drop_pe_edge2", 32'(protocol_error), 32'd1);
    repeat (3) @(posedge clock);
    #1 chk("drop_pe_sticky", 32'(protocol_error), 32'd1);
    do_reset();
    s.ivalid = 1'b1;
    s.idata = 8'd5;
    @(posedge clock);
    #1 s.idata = 8'd6;
    q.push_back(mk(8'd7, 4'd0, 4'd1, 1'b1, 1'b1));
    chk("chg_pe_edge1", 32'(protocol_error), 32'd0);
    @(posedge clock);
    #1 s.ivalid = 1'b0;
    chk("chg_pe_edge2", 32'(protocol_error), 32'd1);
    repeat (3) @(posedge clock);
    #1 chk("chg_pe_sticky", 32'(protocol_error), 32'd1);
    do_reset();
    send(8'd5, mk(8'd6, 4'd0, 4'd1, 1'b1, 1'b0));
    s.ivalid = 1'b0;
    repeat (4) @(posedge clock);
    #1 chk("hold_pe", 32'(protocol_error), 32'd0);
    @(negedge clock);
    #1 chk("sb_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end
endmodule

// File: doc/axis_sequence_checker.md
# axis_sequence_checker

AXI-stream sink that terminates a counter stream (e.g. the output of `axis_counter` or `axis_throttle`) and checks it. It generates programmable back-pressure on `iready` and verifies that accepted beats form a consecutive modulo-2^WIDTH sequence. It also flags violations of the valid/data hold rule and exposes error and beat statistics for LEDs or a debug port. It is the consumer end of the pipeline that `axis_counter` produces into.

## Interface
- WIDTH, 8, data width of the stream.
- STALL_PERIOD, 0, back-pressure period in cycles. 0 or 1 keeps `iready` high after reset; N≥2 drops `iready` for one cycle in every N.
- ERRW, 16, width of the error and beat counters.

- clock  input  1  single system clock; all logic on rising edge.
- resetn  input  1  reset, asynchronous assert, active-low.
- idata  input  WIDTH  stream data.
- ivalid  input  1  stream valid.
- iready  output  1  stream ready; registered.
- expected  output  WIDTH  next value the checker expects; registered.
- locked  output  1  high once the first beat has been accepted.
- errors  output  ERRW  count of sequence mismatches; saturating.
- beats  output  ERRW  count of accepted beats; wraps.
- protocol_error  output  1  sticky; a stalled beat was withdrawn or changed.

## Operation
- A transfer occurs on an edge where `ivalid && iready` is high.
- Reset values: `iready`=0, `expected`=0, `locked`=0, `errors`=0, `beats`=0, `protocol_error`=0, `phase`=0, state HUNT.
- Back-pressure uses an internal `phase` counter, 0..STALL_PERIOD-1, wrapping to 0.
  - On every edge: `phase <= next`, then `iready <= (next != STALL_PERIOD-1)`.
  - For STALL_PERIOD ≤ 1: `iready <= 1` on every edge.
- State machine:
  - HUNT (`locked`=0): on a transfer, `expected <= idata+1` (mod 2^WIDTH), `locked <= 1`, go to TRACK. `errors` is unchanged.
  - TRACK (`locked`=1): on a transfer where `idata == expected`, `expected <= expected+1`.
  - TRACK, mismatch: `errors <= errors+1`, saturating at 2^ERRW-1. Resync with `expected <= idata+1`. Stay in TRACK.
- Wrap-around: `expected` of all-ones followed by `idata` 0 is a match. `expected` wraps to 0 silently.
- `beats` increments on every transfer, including the first and any mismatch, and wraps at 2^ERRW.
- Protocol monitor:
  - It registers `stalled = ivalid && !iready` and the value of `idata` in that cycle.
  - In the next cycle, `protocol_error <= 1` if `stalled` was set and either `ivalid` is now 0 or `idata` differs from the stored value.
  - Cleared only by reset.
- No transfer leaves all statistics unchanged. `ivalid` while `iready`=0 is legal.
- Reset mid-operation returns to HUNT immediately (asynchronous). Any partially observed stall is discarded.

## Timing
- `iready` is a flop output, with no combinational path from any input.
- `expected`, `locked`, `errors` and `beats` reflect a transfer in the cycle after its edge, i.e. 1-cycle latency.
- `protocol_error` rises 1 cycle after the violating cycle, so 2 edges after the stall cycle.
- Throughput for STALL_PERIOD=N≥2 is (N-1)/N beats per cycle. STALL_PERIOD ≤ 1 gives 1 beat per cycle.
- First possible transfer is at the 2nd rising edge after reset release, because `iready` is 0 until the 1st edge.

## Test plan
- STALL_PERIOD=0, source sends 0,1,2,…,9 with `ivalid` always high:
  - `iready` is 1 from the 1st edge onward.
  - After the last transfer: `locked`=1, `expected`=10, `beats`=10, `errors`=0.
- STALL_PERIOD=4:
  - `iready` after reset release reads 0,1,1,0,1,1,1,0,1,1,1,0.
  - A continuous counter stream is accepted with no errors and `beats` increasing 3 per 4 cycles.
- Wrap and mismatch (WIDTH=8): send 254,255,0,1,7,8.
  - `errors`=1, registered on the `7` beat.
  - After the `7` beat: `expected`=8. After the `8` beat: `expected`=9.
- Saturation (ERRW=4): send 20 beats each differing from `expected`.
  - `errors` stops at 15. `beats`=20 mod 16 = 4.
- Protocol violations:
  - Drop `ivalid` during a cycle with `iready`=0 → `protocol_error`=1 two edges later and stays 1.
  - Repeat with `idata` changed by +1 instead → same result.
  - A stall that is held correctly leaves `protocol_error`=0.
- Assert `resetn`=0 mid-stream:
  - All outputs return to reset values without a clock.
  - After release, first accepted value 100 yields `expected`=101, `errors`=0, `beats`=1.
